// File: rtl/ps2_poly_voice_alloc.sv
// PS/2 scancode parser that maps held keys onto NUM_VOICES voices, stealing the
// oldest voice when all are busy, and tracks the Ctrl-driven master volume.
module ps2_poly_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int FCCW_W     = 30,
  parameter int VOL_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx_done_tick,
  input  logic [7:0]                   rx_data,
  output logic [NUM_VOICES*FCCW_W-1:0] voice_fccw,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic [NUM_VOICES-1:0]        voice_release,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [VOL_W-1:0]             volume
);

  localparam int               AGE_W   = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_CTRL = 8'h14;

  logic [1:0]                       state, state_nxt;
  logic [NUM_VOICES-1:0][7:0]       voice_code, voice_code_nxt;
  logic [NUM_VOICES-1:0][AGE_W-1:0] voice_age, voice_age_nxt;
  logic [NUM_VOICES*FCCW_W-1:0]     fccw_nxt;
  logic [NUM_VOICES-1:0]            start_nxt, release_nxt, active_nxt;
  logic [VOL_W-1:0]                 volume_nxt;

  logic             note_hit;
  logic [13:0]      note_fccw;
  logic             held_hit, free_hit;
  logic [AGE_W-1:0] held_idx, free_idx, oldest_idx, oldest_age, alloc_idx;
  logic             do_make, do_break;

  // 12-TET pitch table for a 30-bit accumulator at 100 MHz; two keyboard rows
  // share the same octave so either row can play a melody.
  always_comb begin
    note_hit  = 1'b1;
    note_fccw = '0;
    case (rx_data)
      8'h0E, 8'h1A: note_fccw = 14'd2503;
      8'h0D, 8'h22: note_fccw = 14'd2652;
      8'h15, 8'h1C: note_fccw = 14'd2809;
      8'h1E:        note_fccw = 14'd2976;
      8'h1D, 8'h1B: note_fccw = 14'd3153;
      8'h26:        note_fccw = 14'd3341;
      8'h24, 8'h23: note_fccw = 14'd3539;
      8'h2D, 8'h2B: note_fccw = 14'd3750;
      8'h2E:        note_fccw = 14'd3973;
      8'h2C, 8'h34: note_fccw = 14'd4209;
      8'h36:        note_fccw = 14'd4459;
      8'h35, 8'h33: note_fccw = 14'd4724;
      8'h3D:        note_fccw = 14'd5005;
      8'h3C, 8'h3B: note_fccw = 14'd5303;
      8'h43, 8'h42: note_fccw = 14'd5618;
      8'h46:        note_fccw = 14'd5952;
      8'h44, 8'h4B: note_fccw = 14'd6306;
      8'h45:        note_fccw = 14'd6681;
      8'h4D, 8'h4C: note_fccw = 14'd7079;
      8'h54, 8'h52: note_fccw = 14'd7500;
      8'h55:        note_fccw = 14'd7946;
      8'h5B:        note_fccw = 14'd8418;
      8'h66:        note_fccw = 14'd8919;
      8'h5C:        note_fccw = 14'd9448;
      default:      note_hit  = 1'b0;
    endcase
  end

  // Voice search: the first voice already holding this code, the first idle
  // voice, and the oldest voice (strict > keeps the lowest index on ties).
  always_comb begin
    held_hit   = 1'b0;
    held_idx   = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    oldest_age = voice_age[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!held_hit && voice_active[v] && (voice_code[v] == rx_data)) begin
        held_hit = 1'b1;
        held_idx = AGE_W'(v);
      end
      if (!free_hit && !voice_active[v]) begin
        free_hit = 1'b1;
        free_idx = AGE_W'(v);
      end
      if (voice_age[v] > oldest_age) begin
        oldest_age = voice_age[v];
        oldest_idx = AGE_W'(v);
      end
    end
    alloc_idx = free_hit ? free_idx : oldest_idx;
  end

  always_comb begin
    state_nxt  = state;
    volume_nxt = volume;
    do_make    = 1'b0;
    do_break   = 1'b0;
    if (rx_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == CODE_BRK) begin
            state_nxt = ST_BRK;
          end else if (rx_data == CODE_EXT) begin
            state_nxt = ST_EXT;
          end else if (rx_data == CODE_CTRL) begin
            if (volume != '0) volume_nxt = volume - VOL_W'(1);
          end else begin
            do_make = 1'b1;
          end
        end
        ST_BRK: begin
          do_break  = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT: begin
          if (rx_data == CODE_CTRL) begin
            if (volume != '1) volume_nxt = volume + VOL_W'(1);
            state_nxt = ST_IDLE;
          end else if (rx_data == CODE_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A steal simply re-targets the voice: fresh start pulse, no release.
  always_comb begin
    voice_code_nxt = voice_code;
    voice_age_nxt  = voice_age;
    fccw_nxt       = voice_fccw;
    active_nxt     = voice_active;
    start_nxt      = '0;
    release_nxt    = '0;
    if (do_make && note_hit && !held_hit) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (AGE_W'(v) == alloc_idx) begin
          voice_code_nxt[v]               = rx_data;
          voice_age_nxt[v]                = '0;
          fccw_nxt[v*FCCW_W +: FCCW_W]    = FCCW_W'(note_fccw);
          active_nxt[v]                   = 1'b1;
          start_nxt[v]                    = 1'b1;
        end else if (voice_active[v] && (voice_age[v] != AGE_MAX)) begin
          voice_age_nxt[v] = voice_age[v] + AGE_W'(1);
        end
      end
    end
    if (do_break && held_hit) begin
      active_nxt[held_idx]  = 1'b0;
      release_nxt[held_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      voice_code    <= '0;
      voice_age     <= '0;
      voice_fccw    <= '0;
      voice_start   <= '0;
      voice_release <= '0;
      voice_active  <= '0;
      volume        <= '1;
    end else begin
      state         <= state_nxt;
      voice_code    <= voice_code_nxt;
      voice_age     <= voice_age_nxt;
      voice_fccw    <= fccw_nxt;
      voice_start   <= start_nxt;
      voice_release <= release_nxt;
      voice_active  <= active_nxt;
      volume        <= volume_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_poly_voice_alloc.sv
// Scenario bench for ps2_poly_voice_alloc: expected outputs are queued as bytes
// are driven and compared against the outputs captured one cycle later.
module tb_ps2_poly_voice_alloc;

  localparam int NV = 4;
  localparam int FW = 30;
  localparam int VW = 4;
  localparam int OW = 3 * NV + VW + NV * FW;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             rx_done_tick;
  logic [7:0]       rx_data;
  logic [NV*FW-1:0] voice_fccw;
  logic [NV-1:0]    voice_start;
  logic [NV-1:0]    voice_release;
  logic [NV-1:0]    voice_active;
  logic [VW-1:0]    volume;

  logic [OW-1:0]    sb[$];
  logic [OW-1:0]    obs[$];
  string            tags[$];
  logic [NV*FW-1:0] e_fc;
  int               total = 0;
  int               bad   = 0;

  ps2_poly_voice_alloc #(.NUM_VOICES(NV), .FCCW_W(FW), .VOL_W(VW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_done_tick  (rx_done_tick),
    .rx_data       (rx_data),
    .voice_fccw    (voice_fccw),
    .voice_start   (voice_start),
    .voice_release (voice_release),
    .voice_active  (voice_active),
    .volume        (volume)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: queue the expectation, drive at the falling edge,
  // capture what the DUT registered at the following falling edge.
  task automatic step(input string tag, input bit tk, input logic [7:0] b,
                      input logic [3:0] st, input logic [3:0] rl, input logic [3:0] ac,
                      input logic [VW-1:0] vol, input int fv, input int ff);
    if (fv >= 0) e_fc[fv*FW +: FW] = FW'(ff);
    sb.push_back({st, rl, ac, vol, e_fc});
    tags.push_back(tag);
    rx_done_tick = tk;
    rx_data      = b;
    @(posedge clk);
    @(negedge clk);
    obs.push_back({voice_start, voice_release, voice_active, volume, voice_fccw});
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    rx_done_tick = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    e_fc    = '0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] w, g;
    string t;
    e_fc    = '0;
    reset_n = 1'b0;
    step("rst_tick0", 1, 8'h1C, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("rst_tick1", 1, 8'hF0, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    reset_n = 1'b1;
    step("rst_idle",  0, 8'h1C, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("rst_make",  1, 8'h35, 4'b0001, 4'b0000, 4'b0001, 4'hF, 0, 4724);
    while (sb.size() > 0) begin
      w = sb.pop_front(); g = obs.pop_front(); t = tags.pop_front();
      total++;
      if (g !== w) begin bad++; $display("[TB] FAIL test_reset/%s: got=%h want=%h", t, g, w); end
    end
  endtask

  task automatic test_make_break();
    logic [OW-1:0] w, g;
    string t;
    do_reset();
    step("mk_1c",   1, 8'h1C, 4'b0001, 4'b0000, 4'b0001, 4'hF, 0, 2809);
    step("brk_f0",  1, 8'hF0, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("brk_1c",  1, 8'h1C, 4'b0000, 4'b0001, 4'b0000, 4'hF, -1, 0);
    step("idle",    0, 8'h1C, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    while (sb.size() > 0) begin
      w = sb.pop_front(); g = obs.pop_front(); t = tags.pop_front();
      total++;
      if (g !== w) begin bad++; $display("[TB] FAIL test_make_break/%s: got=%h want=%h", t, g, w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] w, g;
    string t;
    do_reset();
    step("mk_1c",   1, 8'h1C, 4'b0001, 4'b0000, 4'b0001, 4'hF, 0, 2809);
    step("rep_1c",  1, 8'h1C, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("rep_1c2", 1, 8'h1C, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("mk_35",   1, 8'h35, 4'b0010, 4'b0000, 4'b0011, 4'hF, 1, 4724);
    step("idle",    0, 8'h35, 4'b0000, 4'b0000, 4'b0011, 4'hF, -1, 0);
    while (sb.size() > 0) begin
      w = sb.pop_front(); g = obs.pop_front(); t = tags.pop_front();
      total++;
      if (g !== w) begin bad++; $display("[TB] FAIL test_back_to_back/%s: got=%h want=%h", t, g, w); end
    end
  endtask

  task automatic test_steal();
    logic [OW-1:0] w, g;
    string t;
    do_reset();
    step("mk_15",   1, 8'h15, 4'b0001, 4'b0000, 4'b0001, 4'hF, 0, 2809);
    step("mk_1e",   1, 8'h1E, 4'b0010, 4'b0000, 4'b0011, 4'hF, 1, 2976);
    step("mk_1d",   1, 8'h1D, 4'b0100, 4'b0000, 4'b0111, 4'hF, 2, 3153);
    step("mk_26",   1, 8'h26, 4'b1000, 4'b0000, 4'b1111, 4'hF, 3, 3341);
    step("steal_v0",1, 8'h24, 4'b0001, 4'b0000, 4'b1111, 4'hF, 0, 3539);
    step("brk_f0",  1, 8'hF0, 4'b0000, 4'b0000, 4'b1111, 4'hF, -1, 0);
    step("brk_15",  1, 8'h15, 4'b0000, 4'b0000, 4'b1111, 4'hF, -1, 0);
    step("steal_v1",1, 8'h1C, 4'b0010, 4'b0000, 4'b1111, 4'hF, 1, 2809);
    step("brk_f0b", 1, 8'hF0, 4'b0000, 4'b0000, 4'b1111, 4'hF, -1, 0);
    step("brk_24",  1, 8'h24, 4'b0000, 4'b0001, 4'b1110, 4'hF, -1, 0);
    step("idle",    0, 8'h24, 4'b0000, 4'b0000, 4'b1110, 4'hF, -1, 0);
    while (sb.size() > 0) begin
      w = sb.pop_front(); g = obs.pop_front(); t = tags.pop_front();
      total++;
      if (g !== w) begin bad++; $display("[TB] FAIL test_steal/%s: got=%h want=%h", t, g, w); end
    end
  endtask

  task automatic test_volume();
    logic [OW-1:0] w, g;
    string t;
    int    v;
    do_reset();
    step("ext0",    1, 8'hE0, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("inc_sat", 1, 8'h14, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("dec_e",   1, 8'h14, 4'b0000, 4'b0000, 4'b0000, 4'hE, -1, 0);
    step("brk_f0",  1, 8'hF0, 4'b0000, 4'b0000, 4'b0000, 4'hE, -1, 0);
    step("brk_14",  1, 8'h14, 4'b0000, 4'b0000, 4'b0000, 4'hE, -1, 0);
    step("dec_d",   1, 8'h14, 4'b0000, 4'b0000, 4'b0000, 4'hD, -1, 0);
    step("ext1",    1, 8'hE0, 4'b0000, 4'b0000, 4'b0000, 4'hD, -1, 0);
    step("inc_e",   1, 8'h14, 4'b0000, 4'b0000, 4'b0000, 4'hE, -1, 0);
    for (int i = 0; i < 16; i++) begin
      v = (13 - i < 0) ? 0 : 13 - i;
      step($sformatf("dec_%0d", i), 1, 8'h14, 4'b0000, 4'b0000, 4'b0000, VW'(v), -1, 0);
    end
    step("idle",    0, 8'h14, 4'b0000, 4'b0000, 4'b0000, 4'h0, -1, 0);
    while (sb.size() > 0) begin
      w = sb.pop_front(); g = obs.pop_front(); t = tags.pop_front();
      total++;
      if (g !== w) begin bad++; $display("[TB] FAIL test_volume/%s: got=%h want=%h", t, g, w); end
    end
  endtask

  task automatic test_ignored_codes();
    logic [OW-1:0] w, g;
    string t;
    do_reset();
    step("unk_77",  1, 8'h77, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("e0_a",    1, 8'hE0, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("e0_75",   1, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("e0_b",    1, 8'hE0, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("e0f0",    1, 8'hF0, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("e0f0_75", 1, 8'h75, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    step("mk_1c",   1, 8'h1C, 4'b0001, 4'b0000, 4'b0001, 4'hF, 0, 2809);
    step("e0_c",    1, 8'hE0, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("e0f0_b",  1, 8'hF0, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("e0f0_1c", 1, 8'h1C, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("e0_d",    1, 8'hE0, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("e0_35",   1, 8'h35, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    step("mk_35",   1, 8'h35, 4'b0010, 4'b0000, 4'b0011, 4'hF, 1, 4724);
    step("idle",    0, 8'h35, 4'b0000, 4'b0000, 4'b0011, 4'hF, -1, 0);
    while (sb.size() > 0) begin
      w = sb.pop_front(); g = obs.pop_front(); t = tags.pop_front();
      total++;
      if (g !== w) begin bad++; $display("[TB] FAIL test_ignored_codes/%s: got=%h want=%h", t, g, w); end
    end
  endtask

  task automatic test_reset_mid_note();
    logic [OW-1:0] w, g;
    string t;
    do_reset();
    step("mk_1c",   1, 8'h1C, 4'b0001, 4'b0000, 4'b0001, 4'hF, 0, 2809);
    step("mk_35",   1, 8'h35, 4'b0010, 4'b0000, 4'b0011, 4'hF, 1, 4724);
    step("dec",     1, 8'h14, 4'b0000, 4'b0000, 4'b0011, 4'hE, -1, 0);
    e_fc    = '0;
    reset_n = 1'b0;
    step("rst",     1, 8'hF0, 4'b0000, 4'b0000, 4'b0000, 4'hF, -1, 0);
    reset_n = 1'b1;
    step("mk_after",1, 8'h1C, 4'b0001, 4'b0000, 4'b0001, 4'hF, 0, 2809);
    step("idle",    0, 8'h1C, 4'b0000, 4'b0000, 4'b0001, 4'hF, -1, 0);
    while (sb.size() > 0) begin
      w = sb.pop_front(); g = obs.pop_front(); t = tags.pop_front();
      total++;
      if (g !== w) begin bad++; $display("[TB] FAIL test_reset_mid_note/%s: got=%h want=%h", t, g, w); end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    e_fc         = '0;
    @(negedge clk);
    test_reset();
    test_make_break();
    test_back_to_back();
    test_steal();
    test_volume();
    test_ignored_codes();
    test_reset_mid_note();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
